snowbro2_pcm_arb: RTL and testbench
===================================

SNOWBRO2_PCM_ARB -- requirements
Module: snowbro2_pcm_arb

Interface
REQ-001 Parameter TIMEOUT, default 8'd255, maximum number of WAIT cycles without PCM_OK before a fetch is aborted.
REQ-002 Parameter BANKED, default 1, where 1 = bank bits form PCM_ADDR[19:18] and 0 = PCM_ADDR[19:18] forced to 0.
REQ-003 CLK96  input  1  single clock for all logic.
REQ-004 RESET96_N  input  1  asynchronous, active-low reset.
REQ-005 A0_ADDR  input  18  ADPCM client 0 ROM byte address.
REQ-006 A0_BANK  input  2  client 0 bank select.
REQ-007 A0_DATA  output  8  client 0 returned byte, registered.
REQ-008 A0_OK  output  1  A0_DATA is valid for the current A0_ADDR/A0_BANK.
REQ-009 A1_ADDR, A1_BANK, A1_DATA, A1_OK  as REQ-005..008, for client 1.
REQ-010 PCM_CS  output  1  SDRAM PCM port request.
REQ-011 PCM_ADDR  output  20  SDRAM PCM byte address.
REQ-012 PCM_DOUT  input  8  SDRAM PCM data.
REQ-013 PCM_OK  input  1  SDRAM data valid.
REQ-014 TIMEOUT_ERR  output  1  one-cycle pulse when a fetch is aborted.

Function
REQ-015 Each client's last-served key {BANK,ADDR} SHALL be held in a register; when the live key differs from it, the client's pending flag SHALL set and its OK SHALL drop in the same cycle (combinational compare, registered pending).
REQ-016 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
REQ-017 IDLE: if any client is pending, grant by round-robin (priority to the client not served last; client 0 first after reset), latch the granted key, go to ISSUE; otherwise stay.
REQ-018 ISSUE: assert PCM_CS with PCM_ADDR = {BANKED ? BANK : 2'b0, ADDR} of the latched key; go to WAIT; clear the timeout counter.
REQ-019 WAIT: hold PCM_CS and PCM_ADDR stable; PCM_OK SHALL be ignored in the first WAIT cycle (stale-ok guard) and accepted from the second cycle.
REQ-020 On accepted PCM_OK, the granted client's DATA SHALL load PCM_DOUT, its served key SHALL load the latched key, PCM_CS SHALL drop, and the FSM SHALL return to IDLE; client OK rises the following cycle if the live key still equals the served key.
REQ-021 Minimum service latency, key change to OK high, SHALL be 5 cycles (IDLE→ISSUE→WAIT→WAIT+OK→update→OK).
REQ-022 If the granted client's live key changes during WAIT, the returned byte SHALL still complete the SDRAM handshake but SHALL NOT update DATA or the served key; pending remains set and the client is re-fetched.
REQ-023 If the timeout counter reaches TIMEOUT in WAIT, the FSM SHALL drop PCM_CS, pulse TIMEOUT_ERR, leave the client pending, and return to IDLE; round-robin pointer advances.
REQ-024 Both clients requesting the same key SHALL be served by separate fetches; no merging.
REQ-025 The non-granted client's DATA and OK SHALL be unaffected by a grant to the other client.

Reset
REQ-026 On RESET96_N low: FSM=IDLE, PCM_CS=0, PCM_ADDR=0, A0/A1_DATA=0, served keys set to an invalid marker (extra valid bit cleared) so both clients are pending after release, OK outputs=0, TIMEOUT_ERR=0, round-robin pointer selects client 0.
REQ-027 Reset asserted mid-fetch SHALL abort immediately; a PCM_OK arriving after release while in IDLE SHALL be ignored.

Structure
REQ-028 FSM state encodings, the 20-bit key width and the client count (2) SHALL live in shared package snowbro2_pkg.
REQ-029 One sub-module snowbro2_pcm_client SHALL be instantiated twice, holding key register, compare, pending, DATA and OK.

Verification
REQ-030 Reset release, A0=0x00010 bank 0, A1 idle at 0 → client 0 fetched first, PCM_ADDR=0x00010, A0_OK high 5 cycles after release with SDRAM returning OK on the 2nd WAIT cycle.
REQ-031 Both clients change key in the same cycle (A0=0x12345 bank 1, A1=0x00001 bank 2) → two fetches, PCM_ADDR=0x52345 then 0x80001 (or reverse per pointer), each DATA matches its model.
REQ-032 PCM_OK held high continuously → first WAIT cycle ignored, data captured on the second.
REQ-033 A0_ADDR changes during WAIT → first returned byte discarded, A0_OK stays low, refetch at the new address.
REQ-034 PCM_OK never asserted, TIMEOUT=4 → TIMEOUT_ERR pulses after 4 WAIT cycles, client stays pending, other client served next.
REQ-035 RESET96_N pulsed low during WAIT → PCM_CS=0 and outputs at reset values within the same cycle, and both clients refetched after release.

Source files
------------

// File: rtl/snowbro2_pkg.sv
// Shared definitions for the Snow Bros 2 ADPCM ROM arbiter.
// Holds the FSM state encoding, the fetch key width ({BANK,ADDR}) and the
// client count, plus the helper that maps a key onto the SDRAM byte address.
package snowbro2_pkg;

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned KEY_W     = 20;
  localparam int unsigned N_CLIENTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pcm_state_t;

  // Bank bits only reach the SDRAM when the ROM is actually banked.
  function automatic logic [KEY_W-1:0] pcm_addr_of(input logic [KEY_W-1:0] key,
                                                   input bit              banked);
    return banked ? key : {2'b00, key[ADDR_W-1:0]};
  endfunction

endpackage

// File: rtl/snowbro2_pcm_client.sv
// One ADPCM client port of the PCM arbiter.
// Keeps the last-served {BANK,ADDR} key (with a valid bit), compares it with
// the live key, and holds the registered pending flag, returned byte and OK.
//   CLK96, RESET96_N : clock, asynchronous active-low reset
//   ADDR, BANK       : live client key
//   LOAD             : arbiter accepted a byte for this client's latched key
//   LOAD_KEY/DATA    : key and byte to store on LOAD
//   DATA, OK         : returned byte and its validity for the live key
//   PENDING          : client needs a fetch
//   KEY              : live key, for the arbiter's grant/compare logic
module snowbro2_pcm_client
  import snowbro2_pkg::*;
(
  input  logic              CLK96,
  input  logic              RESET96_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [1:0]        BANK,
  input  logic              LOAD,
  input  logic [KEY_W-1:0]  LOAD_KEY,
  input  logic [7:0]        LOAD_DATA,
  output logic [7:0]        DATA,
  output logic              OK,
  output logic              PENDING,
  output logic [KEY_W-1:0]  KEY
);

  logic             valid_q;
  logic [KEY_W-1:0] served_q;
  logic [7:0]       data_q;
  logic             pend_q;
  logic             match;

  assign KEY   = {BANK, ADDR};
  assign match = valid_q && (served_q == KEY);

  // OK follows the compare directly so it drops in the cycle the key moves.
  assign OK      = match;
  assign DATA    = data_q;
  assign PENDING = pend_q;

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      valid_q  <= 1'b0;
      served_q <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (LOAD) begin
        valid_q  <= 1'b1;
        served_q <= LOAD_KEY;
        data_q   <= LOAD_DATA;
      end
      // LOAD is only issued when the live key equals LOAD_KEY, so clearing
      // here is safe; a later key move sets the flag again.
      pend_q <= LOAD ? 1'b0 : (pend_q | ~match);
    end
  end

endmodule

// File: rtl/snowbro2_pcm_arb.sv
// Round-robin arbiter sharing the SDRAM PCM port between two ADPCM clients.
//   CLK96, RESET96_N       : clock, asynchronous active-low reset
//   A0_* / A1_*            : client key in (ADDR, BANK), byte and OK out
//   PCM_CS, PCM_ADDR       : SDRAM request and byte address
//   PCM_DOUT, PCM_OK       : SDRAM returned byte and valid
//   TIMEOUT_ERR            : one-cycle pulse when a fetch is abandoned
module snowbro2_pcm_arb
  import snowbro2_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255,
  parameter bit         BANKED  = 1'b1
) (
  input  logic              CLK96,
  input  logic              RESET96_N,
  input  logic [ADDR_W-1:0] A0_ADDR,
  input  logic [1:0]        A0_BANK,
  output logic [7:0]        A0_DATA,
  output logic              A0_OK,
  input  logic [ADDR_W-1:0] A1_ADDR,
  input  logic [1:0]        A1_BANK,
  output logic [7:0]        A1_DATA,
  output logic              A1_OK,
  output logic              PCM_CS,
  output logic [KEY_W-1:0]  PCM_ADDR,
  input  logic [7:0]        PCM_DOUT,
  input  logic              PCM_OK,
  output logic              TIMEOUT_ERR
);

  pcm_state_t             state_q, state_d;
  logic                   gnt_q, gnt_d;
  logic                   rr_q, rr_d;
  logic [KEY_W-1:0]       lkey_q, lkey_d;
  logic [KEY_W-1:0]       addr_q, addr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;
  logic                   accept;
  logic [N_CLIENTS-1:0]   pend;
  logic [N_CLIENTS-1:0]   load;
  logic [KEY_W-1:0]       key [N_CLIENTS];

  snowbro2_pcm_client u_client0 (
    .CLK96     (CLK96),
    .RESET96_N (RESET96_N),
    .ADDR      (A0_ADDR),
    .BANK      (A0_BANK),
    .LOAD      (load[0]),
    .LOAD_KEY  (lkey_q),
    .LOAD_DATA (PCM_DOUT),
    .DATA      (A0_DATA),
    .OK        (A0_OK),
    .PENDING   (pend[0]),
    .KEY       (key[0])
  );

  snowbro2_pcm_client u_client1 (
    .CLK96     (CLK96),
    .RESET96_N (RESET96_N),
    .ADDR      (A1_ADDR),
    .BANK      (A1_BANK),
    .LOAD      (load[1]),
    .LOAD_KEY  (lkey_q),
    .LOAD_DATA (PCM_DOUT),
    .DATA      (A1_DATA),
    .OK        (A1_OK),
    .PENDING   (pend[1]),
    .KEY       (key[1])
  );

  // cnt_q is 0 only in the first WAIT cycle, where a stale PCM_OK left over
  // from the previous request must not be taken.
  assign accept      = PCM_OK && (cnt_q != '0);
  assign PCM_CS      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign PCM_ADDR    = addr_q;
  assign TIMEOUT_ERR = tmo_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    lkey_d  = lkey_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    load    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          gnt_d   = (&pend) ? rr_q : pend[1];
          lkey_d  = key[gnt_d];
          addr_d  = pcm_addr_of(lkey_d, BANKED);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (accept) begin
          // A key that moved mid-fetch still finishes the handshake but the
          // byte is dropped; the client stays pending and is fetched again.
          if (key[gnt_q] == lkey_q) load[gnt_q] = 1'b1;
          rr_d    = ~gnt_q;
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          tmo_d   = 1'b1;
          rr_d    = ~gnt_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      lkey_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      lkey_q  <= lkey_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_snowbro2_pcm_arb.sv
// Directed bench for snowbro2_pcm_arb (TIMEOUT=4, banked addressing).
// The SDRAM model answers on the negative clock edge; the bench drives and
// samples 1 time unit after each rising edge.
module tb_snowbro2_pcm_arb;

  logic        CLK96 = 1'b0;
  logic        RESET96_N;
  logic [17:0] A0_ADDR, A1_ADDR;
  logic [1:0]  A0_BANK, A1_BANK;
  logic [7:0]  A0_DATA, A1_DATA;
  logic        A0_OK, A1_OK;
  logic        PCM_CS;
  logic [19:0] PCM_ADDR;
  logic [7:0]  PCM_DOUT;
  logic        PCM_OK;
  logic        TIMEOUT_ERR;

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0: OK on 2nd WAIT cycle, 1: OK always high, 2: never OK
  int cs_cnt = 0;

  snowbro2_pcm_arb #(.TIMEOUT(8'd4), .BANKED(1'b1)) dut (
    .CLK96       (CLK96),
    .RESET96_N   (RESET96_N),
    .A0_ADDR     (A0_ADDR),
    .A0_BANK     (A0_BANK),
    .A0_DATA     (A0_DATA),
    .A0_OK       (A0_OK),
    .A1_ADDR     (A1_ADDR),
    .A1_BANK     (A1_BANK),
    .A1_DATA     (A1_DATA),
    .A1_OK       (A1_OK),
    .PCM_CS      (PCM_CS),
    .PCM_ADDR    (PCM_ADDR),
    .PCM_DOUT    (PCM_DOUT),
    .PCM_OK      (PCM_OK),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK96 = ~CLK96;

  // ROM contents: low byte ^ middle byte ^ top nibble of the byte address.
  function automatic logic [7:0] rom_byte(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
  endfunction

  // SDRAM model. cs_cnt = cycles PCM_CS has been high including this one
  // (1 = ISSUE, 2 = first WAIT, 3 = second WAIT). In mode 1 the first WAIT
  // cycle carries a poisoned byte so an early capture is visible.
  initial begin
    PCM_OK   = 1'b0;
    PCM_DOUT = 8'h00;
    forever begin
      @(negedge CLK96);
      if (PCM_CS) cs_cnt++; else cs_cnt = 0;
      case (mode)
        0:       PCM_OK = (cs_cnt >= 3);
        1:       PCM_OK = 1'b1;
        default: PCM_OK = 1'b0;
      endcase
      PCM_DOUT = (mode == 1 && cs_cnt == 2) ? 8'hEE : rom_byte(PCM_ADDR);
    end
  end

  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  task automatic test_reset();
    RESET96_N = 1'b0;
    A0_ADDR = 18'h00010; A0_BANK = 2'd0;
    A1_ADDR = 18'h00000; A1_BANK = 2'd0;
    mode = 0;
    repeat (3) tick();
    total++; if (PCM_CS !== 1'b0) begin bad++; $display("FAIL rst_cs got=%b want=0", PCM_CS); end
    total++; if (PCM_ADDR !== 20'h0) begin bad++; $display("FAIL rst_addr got=%h want=00000", PCM_ADDR); end
    total++; if ({A0_DATA, A1_DATA} !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want=0000", {A0_DATA, A1_DATA}); end
    total++; if ({A0_OK, A1_OK, TIMEOUT_ERR} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {A0_OK, A1_OK, TIMEOUT_ERR}); end
  endtask

  task automatic test_first_fetch();
    RESET96_N = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) begin
        total++; if (PCM_CS !== 1'b1) begin bad++; $display("FAIL first_cs got=%b want=1", PCM_CS); end
        total++; if (PCM_ADDR !== 20'h00010) begin bad++; $display("FAIL first_addr got=%h want=00010", PCM_ADDR); end
      end
      if (c < 5) begin
        total++; if (A0_OK !== 1'b0) begin bad++; $display("FAIL first_ok_early cyc=%0d got=%b want=0", c, A0_OK); end
      end
    end
    total++; if (A0_OK !== 1'b1) begin bad++; $display("FAIL first_ok_lat5 got=%b want=1", A0_OK); end
    total++; if (A0_DATA !== 8'h10) begin bad++; $display("FAIL first_data got=%h want=10", A0_DATA); end
    for (int i = 0; i < 20 && !A1_OK; i++) tick();
    total++; if ({A0_OK, A1_OK, A1_DATA} !== 10'b11_0000_0000) begin bad++; $display("FAIL first_a1 got=%b want=1100000000", {A0_OK, A1_OK, A1_DATA}); end
  endtask

  task automatic test_both_change();
    logic [19:0] a [4];
    int n = 0;
    logic prev;
    A0_ADDR = 18'h12345; A0_BANK = 2'd1;
    A1_ADDR = 18'h00001; A1_BANK = 2'd2;
    #1;
    total++; if ({A0_OK, A1_OK} !== 2'b00) begin bad++; $display("FAIL both_ok_drop got=%b want=00", {A0_OK, A1_OK}); end
    prev = PCM_CS;
    for (int i = 0; i < 40 && !(A0_OK && A1_OK); i++) begin
      tick();
      if (PCM_CS && !prev && n < 4) begin a[n] = PCM_ADDR; n++; end
      prev = PCM_CS;
    end
    total++; if (n !== 2) begin bad++; $display("FAIL both_nfetch got=%0d want=2", n); end
    total++; if (a[0] !== 20'h52345) begin bad++; $display("FAIL both_addr0 got=%h want=52345", a[0]); end
    total++; if (a[1] !== 20'h80001) begin bad++; $display("FAIL both_addr1 got=%h want=80001", a[1]); end
    total++; if ({A0_OK, A1_OK} !== 2'b11) begin bad++; $display("FAIL both_ok got=%b want=11", {A0_OK, A1_OK}); end
    total++; if (A0_DATA !== 8'h63) begin bad++; $display("FAIL both_a0_data got=%h want=63", A0_DATA); end
    total++; if (A1_DATA !== 8'h09) begin bad++; $display("FAIL both_a1_data got=%h want=09", A1_DATA); end
  endtask

  task automatic test_ok_held();
    mode = 1;
    A0_ADDR = 18'h00200; A0_BANK = 2'd3;
    repeat (4) tick();
    total++; if (A0_OK !== 1'b0) begin bad++; $display("FAIL held_ok_early got=%b want=0", A0_OK); end
    tick();
    total++; if (A0_OK !== 1'b1) begin bad++; $display("FAIL held_ok_lat5 got=%b want=1", A0_OK); end
    total++; if (A0_DATA !== 8'h0E) begin bad++; $display("FAIL held_data got=%h want=0e", A0_DATA); end
    mode = 0;
    tick();
  endtask

  task automatic test_change_in_wait();
    int n = 0;
    logic [19:0] a;
    logic prev;
    A0_ADDR = 18'h00300; A0_BANK = 2'd0;
    tick();
    tick();
    total++; if (PCM_ADDR !== 20'h00300) begin bad++; $display("FAIL chg_addr1 got=%h want=00300", PCM_ADDR); end
    tick();
    A0_ADDR = 18'h00405;
    tick();
    tick();
    total++; if ({PCM_CS, A0_OK} !== 2'b00) begin bad++; $display("FAIL chg_discard_flags got=%b want=00", {PCM_CS, A0_OK}); end
    total++; if (A0_DATA !== 8'h0E) begin bad++; $display("FAIL chg_discard_data got=%h want=0e", A0_DATA); end
    a = '0;
    prev = PCM_CS;
    for (int i = 0; i < 20 && !A0_OK; i++) begin
      tick();
      if (PCM_CS && !prev) begin a = PCM_ADDR; n++; end
      prev = PCM_CS;
    end
    total++; if (n !== 1 || a !== 20'h00405) begin bad++; $display("FAIL chg_refetch got=%0d/%h want=1/00405", n, a); end
    total++; if ({A0_OK, A0_DATA} !== 9'h101) begin bad++; $display("FAIL chg_result got=%h want=101", {A0_OK, A0_DATA}); end
    total++; if ({A1_OK, A1_DATA} !== 9'h109) begin bad++; $display("FAIL chg_other got=%h want=109", {A1_OK, A1_DATA}); end
  endtask

  task automatic test_timeout();
    mode = 2;
    A0_ADDR = 18'h00055; A0_BANK = 2'd0;
    A1_ADDR = 18'h00007; A1_BANK = 2'd0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) begin
        total++; if (PCM_ADDR !== 20'h00007) begin bad++; $display("FAIL tmo_addr got=%h want=00007", PCM_ADDR); end
      end
      total++; if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL tmo_early cyc=%0d got=%b want=0", c, TIMEOUT_ERR); end
    end
    total++; if (PCM_CS !== 1'b1) begin bad++; $display("FAIL tmo_cs_held got=%b want=1", PCM_CS); end
    tick();
    total++; if ({TIMEOUT_ERR, PCM_CS, A1_OK} !== 3'b100) begin bad++; $display("FAIL tmo_pulse got=%b want=100", {TIMEOUT_ERR, PCM_CS, A1_OK}); end
    mode = 0;
    tick();
    total++; if ({TIMEOUT_ERR, PCM_CS} !== 2'b01) begin bad++; $display("FAIL tmo_next got=%b want=01", {TIMEOUT_ERR, PCM_CS}); end
    total++; if (PCM_ADDR !== 20'h00055) begin bad++; $display("FAIL tmo_other_addr got=%h want=00055", PCM_ADDR); end
    for (int i = 0; i < 40 && !(A0_OK && A1_OK); i++) tick();
    total++; if ({A0_OK, A1_OK} !== 2'b11) begin bad++; $display("FAIL tmo_ok got=%b want=11", {A0_OK, A1_OK}); end
    total++; if ({A0_DATA, A1_DATA} !== 16'h5507) begin bad++; $display("FAIL tmo_data got=%h want=5507", {A0_DATA, A1_DATA}); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] a [4];
    int n = 0;
    logic prev;
    mode = 0;
    A0_ADDR = 18'h00066;
    tick();
    tick();
    total++; if (PCM_CS !== 1'b1) begin bad++; $display("FAIL rmid_cs_before got=%b want=1", PCM_CS); end
    tick();
    RESET96_N = 1'b0;
    #1;
    total++; if ({PCM_CS, TIMEOUT_ERR, A0_OK, A1_OK} !== 4'b0000) begin bad++; $display("FAIL rmid_flags got=%b want=0000", {PCM_CS, TIMEOUT_ERR, A0_OK, A1_OK}); end
    total++; if ({PCM_ADDR, A0_DATA, A1_DATA} !== 36'h0) begin bad++; $display("FAIL rmid_vals got=%h want=0", {PCM_ADDR, A0_DATA, A1_DATA}); end
    tick();
    tick();
    mode = 1;
    RESET96_N = 1'b1;
    prev = PCM_CS;
    for (int i = 0; i < 40 && !(A0_OK && A1_OK); i++) begin
      tick();
      if (PCM_CS && !prev && n < 4) begin a[n] = PCM_ADDR; n++; end
      prev = PCM_CS;
    end
    total++; if (n !== 2) begin bad++; $display("FAIL rmid_nfetch got=%0d want=2", n); end
    total++; if (a[0] !== 20'h00066 || a[1] !== 20'h00007) begin bad++; $display("FAIL rmid_order got=%h,%h want=00066,00007", a[0], a[1]); end
    total++; if ({A0_OK, A1_OK, A0_DATA, A1_DATA} !== 18'h36607) begin bad++; $display("FAIL rmid_result got=%h want=36607", {A0_OK, A1_OK, A0_DATA, A1_DATA}); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_both_change();
    test_ok_held();
    test_change_in_wait();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
